// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and decode helpers for the data memory unit.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } dmem_state_t;

    function automatic logic misaligned(input mem_size_t size, input logic [1:0] lane);
        return (size == SZ_HALF && lane[0]) || (size == SZ_WORD && lane != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: little-endian store merge and load extract/extend for one word.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  mem_size_t   size,
    input  logic [1:0]  lane,
    input  logic        is_signed,
    output logic [31:0] new_word,
    output logic [31:0] load_val
);
    logic [3:0]  be;
    logic [31:0] wide;
    logic [15:0] shifted;

    // Replicating the store data lets every byte lane pick from the same position.
    assign be   = size == SZ_BYTE ? 4'b0001 << lane
                : size == SZ_HALF ? (lane[1] ? 4'b1100 : 4'b0011)
                : 4'b1111;
    assign wide = size == SZ_BYTE ? {4{wdata[7:0]}}
                : size == SZ_HALF ? {2{wdata[15:0]}}
                : wdata;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign new_word[8*i +: 8] = be[i] ? wide[8*i +: 8] : old_word[8*i +: 8];
    end

    assign shifted  = 16'(old_word >> {lane, 3'b000});
    assign load_val = size == SZ_BYTE ? {{24{is_signed & shifted[7]}}, shifted[7:0]}
                    : size == SZ_HALF ? {{16{is_signed & shifted[15]}}, shifted}
                    : old_word;
endmodule

// File: rtl/data_memory_unit.sv
// data_memory_unit: MEM-stage data memory with sized accesses, faults and wait states.
// The access commits on the edge entering DONE; ready is high for the DONE cycle only.
module data_memory_unit
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] alu_res,
    input  logic [31:0] rm_val,
    input  logic [1:0]  mem_size,
    input  logic        mem_signed,
    output logic [31:0] data_mem,
    output logic        ready,
    output logic        fault
);
    localparam int IW = $clog2(DEPTH);

    logic [31:0]  mem [DEPTH];
    dmem_state_t  state, next_state;
    logic [3:0]   count, next_count;
    logic         req, commit, out_of_range, err;
    logic [29:0]  word_off;
    logic [IW-1:0] index;
    logic [31:0]  old_word, new_word, load_val;
    mem_size_t    size;

    assign size = mem_size_t'(mem_size);
    assign req  = MEM_R_EN | MEM_W_EN;

    // BASE_ADDR is word aligned, so subtracting at word granularity matches the byte offset.
    assign word_off     = alu_res[31:2] - 30'(BASE_ADDR / 4);
    assign index        = word_off[IW-1:0];
    assign out_of_range = (alu_res < 32'(BASE_ADDR)) || (word_off >= 30'(DEPTH));
    assign err          = out_of_range || misaligned(size, alu_res[1:0]) || size == SZ_RSVD;
    assign old_word     = mem[index];
    assign ready        = state == DONE;

    dmem_lane_align u_align (
        .old_word (old_word),
        .wdata    (rm_val),
        .size     (size),
        .lane     (alu_res[1:0]),
        .is_signed(mem_signed),
        .new_word (new_word),
        .load_val (load_val)
    );

    always_comb begin
        next_state = state;
        next_count = count;
        commit     = 1'b0;
        case (state)
            IDLE: if (req) begin
                if (WAIT_STATES == 0) begin
                    next_state = DONE;
                    commit     = 1'b1;
                end else begin
                    next_state = BUSY;
                    next_count = 4'(WAIT_STATES - 1);
                end
            end
            BUSY: if (count != 4'd0) begin
                next_count = count - 4'd1;
            end else begin
                next_state = DONE;
                commit     = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= 4'd0;
            data_mem <= 32'd0;
            fault    <= 1'b0;
        end else begin
            state <= next_state;
            count <= next_count;
            if (commit) begin
                fault    <= err;
                data_mem <= (err || MEM_W_EN) ? 32'd0 : load_val;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
        end else if (commit && MEM_W_EN && !err) begin
            mem[index] <= new_word;
        end
    end
endmodule

// File: tb/tb_data_memory_unit.sv
// tb_data_memory_unit: directed and random accesses against a byte-array reference model,
// on a 2-wait-state instance (inst 0) and a zero-wait-state instance (inst 1).
module tb_data_memory_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r_en2 = 1'b0, w_en2 = 1'b0, r_en0 = 1'b0, w_en0 = 1'b0;
    logic [31:0] alu_res = 32'd0, rm_val = 32'd0;
    logic [1:0]  mem_size = 2'd0;
    logic        mem_signed = 1'b0;
    logic [31:0] data2, data0;
    logic        ready2, ready0, fault2, fault0;

    int total = 0;
    int bad = 0;
    logic [7:0] mm [2][256];

    always #5 clk = ~clk;

    data_memory_unit #(.DEPTH(64), .BASE_ADDR(1024), .WAIT_STATES(2)) dut2 (
        .clk(clk), .rst(rst), .MEM_R_EN(r_en2), .MEM_W_EN(w_en2), .alu_res(alu_res),
        .rm_val(rm_val), .mem_size(mem_size), .mem_signed(mem_signed),
        .data_mem(data2), .ready(ready2), .fault(fault2)
    );

    data_memory_unit #(.DEPTH(64), .BASE_ADDR(1024), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .MEM_R_EN(r_en0), .MEM_W_EN(w_en0), .alu_res(alu_res),
        .rm_val(rm_val), .mem_size(mem_size), .mem_signed(mem_signed),
        .data_mem(data0), .ready(ready0), .fault(fault0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 256; i++) mm[k][i] = 8'h00;
    endtask

    // Computes the expected outcome from the address/size rules, then runs one handshake.
    task automatic access(input int inst, input bit w, input bit r, input logic [31:0] a,
                          input logic [1:0] sz, input bit sg, input logic [31:0] wd,
                          input string tag);
        logic [31:0] exp_d, v;
        bit exp_f;
        int nb, off, n;
        nb    = 1 << sz;
        exp_f = (a < 32'd1024) || (a >= 32'd1280) || sz == 2'd3 || (a % nb != 0);
        exp_d = 32'd0;
        off   = int'(a) - 1024;
        if (!exp_f && w) begin
            for (int i = 0; i < nb; i++) mm[inst][off + i] = 8'(wd >> (8 * i));
        end else if (!exp_f) begin
            v = 32'd0;
            for (int i = 0; i < nb; i++) v = v | (32'(mm[inst][off + i]) << (8 * i));
            if (sg && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
            exp_d = v;
        end
        alu_res = a; rm_val = wd; mem_size = sz; mem_signed = sg;
        if (inst == 0) begin w_en2 = w; r_en2 = r; end
        else begin w_en0 = w; r_en0 = r; end
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(inst == 0 ? ready2 : ready0) && n < 10);
        chk({tag, "_latency"}, 32'(n), inst == 0 ? 32'd3 : 32'd1);
        chk({tag, "_fault"}, 32'(inst == 0 ? fault2 : fault0), 32'(exp_f));
        chk({tag, "_data"}, inst == 0 ? data2 : data0, exp_d);
        w_en2 = 1'b0; r_en2 = 1'b0; w_en0 = 1'b0; r_en0 = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_ready_drop"}, 32'(inst == 0 ? ready2 : ready0), 32'd0);
    endtask

    initial begin
        logic [31:0] a, wd;
        logic [1:0]  sz;
        bit          w;
        clear_model();
        #1;
        chk("rst_ready2", 32'(ready2), 32'd0);
        chk("rst_fault2", 32'(fault2), 32'd0);
        chk("rst_data2", data2, 32'd0);
        chk("rst_ready0", 32'(ready0), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        access(0, 1, 0, 32'd1024, 2'd2, 0, 32'hDEAD_BEEF, "st_w1024");
        access(0, 0, 1, 32'd1024, 2'd2, 0, 32'h0, "ld_w1024");
        access(0, 1, 0, 32'd1029, 2'd0, 0, 32'h0000_00A5, "st_b1029");
        access(0, 0, 1, 32'd1029, 2'd0, 1, 32'h0, "ld_sb1029");
        access(0, 0, 1, 32'd1029, 2'd0, 0, 32'h0, "ld_ub1029");
        access(0, 0, 1, 32'd1028, 2'd2, 0, 32'h0, "ld_w1028a");
        access(0, 1, 0, 32'd1030, 2'd1, 0, 32'h0000_8001, "st_h1030");
        access(0, 0, 1, 32'd1030, 2'd1, 1, 32'h0, "ld_sh1030");
        access(0, 0, 1, 32'd1028, 2'd2, 0, 32'h0, "ld_w1028b");
        access(0, 0, 1, 32'd1026, 2'd2, 0, 32'h0, "ld_w1026_mis");
        access(0, 1, 0, 32'd1025, 2'd1, 0, 32'h0000_7777, "st_h1025_mis");
        access(0, 0, 1, 32'd1024, 2'd2, 0, 32'h0, "ld_w1024_keep");
        access(0, 1, 0, 32'd1280, 2'd2, 0, 32'h1111_1111, "st_1280_oor");
        access(0, 1, 0, 32'd1020, 2'd2, 0, 32'h2222_2222, "st_1020_oor");
        access(0, 1, 0, 32'd1276, 2'd2, 0, 32'h3333_4444, "st_last");
        access(0, 0, 1, 32'd1276, 2'd2, 0, 32'h0, "ld_last");
        access(0, 0, 1, 32'd1024, 2'd3, 0, 32'h0, "ld_rsvd");
        access(0, 1, 1, 32'd1032, 2'd2, 0, 32'h1234_5678, "st_both");
        access(0, 0, 1, 32'd1032, 2'd2, 0, 32'h0, "ld_both");

        repeat (40) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = 32'd1024 + 32'(4 * $urandom_range(0, 63));
            if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(0, 3));
            else if (sz == 2'd0) a = a + 32'($urandom_range(0, 3));
            else if (sz == 2'd1) a = a + 32'(2 * $urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) a = $urandom_range(0, 1) ? 32'd1016 : 32'd1284;
            w  = 1'($urandom_range(0, 1));
            wd = $urandom;
            access(0, w, !w || 1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), wd, "rnd");
        end

        access(0, 0, 1, 32'd1029, 2'd0, 0, 32'h0, "pre_rst_ld");
        alu_res = 32'd1036; rm_val = 32'hCAFE_F00D; mem_size = 2'd2; w_en2 = 1'b1;
        @(posedge clk); #1;
        chk("busy_ready", 32'(ready2), 32'd0);
        rst = 1'b1;
        #1;
        chk("arst_ready", 32'(ready2), 32'd0);
        chk("arst_fault", 32'(fault2), 32'd0);
        chk("arst_data", data2, 32'd0);
        clear_model();
        w_en2 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("post_rst_no_ready", 32'(ready2), 32'd0);
        end
        access(0, 0, 1, 32'd1036, 2'd2, 0, 32'h0, "ld_1036_after_rst");
        access(0, 0, 1, 32'd1024, 2'd2, 0, 32'h0, "ld_1024_after_rst");

        access(1, 1, 0, 32'd1024, 2'd2, 0, $urandom, "z_st1024");
        access(1, 1, 0, 32'd1028, 2'd2, 0, $urandom, "z_st1028");
        alu_res = 32'd1024; mem_size = 2'd2; mem_signed = 1'b0; r_en0 = 1'b1;
        @(posedge clk); #1;
        chk("b2b_ready1", 32'(ready0), 32'd1);
        chk("b2b_data1", data0, {mm[1][3], mm[1][2], mm[1][1], mm[1][0]});
        alu_res = 32'd1028;
        @(posedge clk); #1;
        chk("b2b_idle_gap", 32'(ready0), 32'd0);
        @(posedge clk); #1;
        chk("b2b_ready2", 32'(ready0), 32'd1);
        chk("b2b_data2", data0, {mm[1][7], mm[1][6], mm[1][5], mm[1][4]});
        r_en0 = 1'b0;
        @(posedge clk); #1;
        repeat (12) begin
            sz = 2'($urandom_range(0, 2));
            a  = 32'd1024 + 32'(4 * $urandom_range(0, 3)) + (sz == 2'd0 ? 32'($urandom_range(0, 3)) : 32'd0);
            w  = 1'($urandom_range(0, 1));
            access(1, w, !w, a, sz, 1'($urandom_range(0, 1)), $urandom, "z_rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
